// File: rtl/qspi_cmd_engine.sv
// -----------------------------------------------------------------------------
// qspi_cmd_engine
//
// Serial back end of the flash test path. It takes one flash transaction at a
// time from the command sequencer and serialises it onto the QSPI pins with
// SCK running at clk_25M/2 (SPI mode 0). Read transactions return the captured
// byte on O_read_data. Every accepted request ends with a one-cycle O_done_sig
// pulse.
//
// Ports:
//   clk_25M        in   1   25 MHz system clock
//   I_rst_n        in   1   asynchronous reset, active low
//   I_cmd_type     in   5   bit4 = request valid, [3:0] = transaction select
//   I_flash_cmd    in   8   opcode
//   I_flash_addr   in  24   address, MSB first
//   I_status_reg   in  16   write-NVCR payload (low byte sent first)
//   I_test_vec     in   8   program data byte
//   I_qspi_dq_in   in   4   pad inputs DQ[3:0] (read data arrives on DQ1)
//   O_done_sig     out  1   one-cycle completion pulse
//   O_read_data    out  8   last byte read
//   O_qspi_clk     out  1   SCK
//   O_qspi_cs_n    out  1   chip select, active low
//   O_qspi_dq_out  out  4   pad outputs
//   O_qspi_dq_oe   out  4   pad output enables
// -----------------------------------------------------------------------------
module qspi_cmd_engine (
    input  logic        clk_25M,
    input  logic        I_rst_n,
    input  logic [4:0]  I_cmd_type,
    input  logic [7:0]  I_flash_cmd,
    input  logic [23:0] I_flash_addr,
    input  logic [15:0] I_status_reg,
    input  logic [7:0]  I_test_vec,
    input  logic [3:0]  I_qspi_dq_in,
    output logic        O_done_sig,
    output logic [7:0]  O_read_data,
    output logic        O_qspi_clk,
    output logic        O_qspi_cs_n,
    output logic [3:0]  O_qspi_dq_out,
    output logic [3:0]  O_qspi_dq_oe
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_DONE
    } state_t;

    state_t      state;
    state_t      next_state;

    // Outgoing bits are always taken from the top of tx_shift; the payload is
    // packed MSB-first at acceptance so one shifter serves every transaction.
    logic [47:0] tx_shift;
    logic [7:0]  rx_shift;
    logic [7:0]  read_data;
    logic [5:0]  bit_cnt;
    logic [5:0]  n_bits;
    logic        is_read;
    logic        is_quad;
    logic        sck_phase;

    logic [5:0]  dec_bits;
    logic        dec_read;
    logic        dec_quad;
    logic        dec_known;

    logic        last_bit;
    logic        in_read;
    logic        in_quad;

    // Only DQ1 carries read data in the supported transactions.
    logic        unused_dq_in;
    assign unused_dq_in = &{1'b0, I_qspi_dq_in[3:2], I_qspi_dq_in[0]};

    // Transaction decode: total SCK cycles and which tail phase follows the
    // single-line header. Reads switch after the 8-bit opcode, quad program
    // after opcode + address (32 bits).
    always_comb begin
        dec_bits  = 6'd0;
        dec_read  = 1'b0;
        dec_quad  = 1'b0;
        dec_known = 1'b1;
        case (I_cmd_type[3:0])
            4'h0:    begin dec_bits = 6'd16; dec_read = 1'b1; end
            4'h1:    dec_bits = 6'd8;
            4'h2:    dec_bits = 6'd32;
            4'h3:    begin dec_bits = 6'd16; dec_read = 1'b1; end
            4'h5:    dec_bits = 6'd40;
            4'h6:    dec_bits = 6'd24;
            4'h8:    begin dec_bits = 6'd34; dec_quad = 1'b1; end
            default: dec_known = 1'b0;
        endcase
    end

    assign last_bit = (bit_cnt == (n_bits - 6'd1));
    assign in_read  = is_read && (bit_cnt >= 6'd8);
    assign in_quad  = is_quad && (bit_cnt >= 6'd32);

    // State register.
    always_ff @(posedge clk_25M or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and pin outputs. Unknown codes skip straight to DONE so the
    // sequencer still sees a completion without any pin activity. DONE always
    // returns to IDLE, which keeps CS_n high for at least two clocks.
    always_comb begin
        next_state    = state;
        O_qspi_cs_n   = 1'b1;
        O_qspi_clk    = 1'b0;
        O_qspi_dq_out = 4'b1100;
        O_qspi_dq_oe  = 4'b1100;
        O_done_sig    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (I_cmd_type[4]) begin
                    next_state = dec_known ? ST_SETUP : ST_DONE;
                end
            end
            ST_SETUP: begin
                O_qspi_cs_n   = 1'b0;
                O_qspi_dq_out = {3'b110, tx_shift[47]};
                O_qspi_dq_oe  = 4'b1101;
                next_state    = ST_SHIFT;
            end
            ST_SHIFT: begin
                O_qspi_cs_n = 1'b0;
                O_qspi_clk  = sck_phase;
                if (in_quad) begin
                    O_qspi_dq_out = tx_shift[47:44];
                    O_qspi_dq_oe  = 4'b1111;
                end else if (in_read) begin
                    O_qspi_dq_out = 4'b1100;
                    O_qspi_dq_oe  = 4'b1100;
                end else begin
                    O_qspi_dq_out = {3'b110, tx_shift[47]};
                    O_qspi_dq_oe  = 4'b1101;
                end
                if (sck_phase && last_bit) begin
                    next_state = ST_HOLD;
                end
            end
            ST_HOLD: begin
                O_qspi_cs_n   = 1'b0;
                O_qspi_dq_out = 4'b1100;
                O_qspi_dq_oe  = 4'b1101;
                next_state    = ST_DONE;
            end
            ST_DONE: begin
                O_done_sig = 1'b1;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Datapath. The edge that closes each SCK-high phase advances the bit
    // counter, moves the shifter and samples DQ1 during a read phase. The read
    // byte is published on the HOLD->DONE edge so it is valid alongside done.
    always_ff @(posedge clk_25M or negedge I_rst_n) begin
        if (!I_rst_n) begin
            tx_shift  <= '0;
            rx_shift  <= '0;
            read_data <= '0;
            bit_cnt   <= '0;
            n_bits    <= '0;
            is_read   <= 1'b0;
            is_quad   <= 1'b0;
            sck_phase <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (I_cmd_type[4]) begin
                        n_bits    <= dec_bits;
                        is_read   <= dec_read;
                        is_quad   <= dec_quad;
                        bit_cnt   <= '0;
                        sck_phase <= 1'b0;
                        if (I_cmd_type[3:0] == 4'h6) begin
                            tx_shift <= {I_flash_cmd, I_status_reg[7:0],
                                         I_status_reg[15:8], 24'h000000};
                        end else begin
                            tx_shift <= {I_flash_cmd, I_flash_addr,
                                         I_test_vec, 8'h00};
                        end
                    end
                end
                ST_SHIFT: begin
                    sck_phase <= ~sck_phase;
                    if (sck_phase) begin
                        bit_cnt <= bit_cnt + 6'd1;
                        if (in_quad) begin
                            tx_shift <= {tx_shift[43:0], 4'h0};
                        end else begin
                            tx_shift <= {tx_shift[46:0], 1'b0};
                        end
                        if (in_read) begin
                            rx_shift <= {rx_shift[6:0], I_qspi_dq_in[1]};
                        end
                    end
                end
                ST_HOLD: begin
                    if (is_read) begin
                        read_data <= rx_shift;
                    end
                end
                default: ;
            endcase
        end
    end

    assign O_read_data = read_data;

endmodule
